// File: rtl/countdown_display.sv
// Countdown display driver: double-dabble BCD conversion, 4-digit mux
// with leading-zero blanking, and lamp decode with blink support.
module countdown_display #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] num,
    input  logic [2:0] color,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [2:0] main_ryg,
    output logic [2:0] side_ryg,
    output logic       ped_walk
);

    localparam int DW = $clog2(DIGIT_CYCLES);
    localparam int BW = $clog2(BLINK_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_t;

    conv_t         state_q, state_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    last_q, last_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [3:0]    hun_q, hun_d;
    logic [3:0]    ten_q, ten_d;
    logic [3:0]    one_q, one_d;
    logic [19:0]   dd;

    logic [DW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d;

    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic [2:0]    main_q, main_d;
    logic [2:0]    side_q, side_d;
    logic          walk_q, walk_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        hun_d   = hun_q;
        ten_d   = ten_q;
        one_d   = one_q;
        dd      = {bcd_q, sh_q};
        unique case (state_q)
            IDLE: begin
                if (!valid_q || num != last_q) begin
                    sh_d    = num;
                    last_d  = num;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int k = 0; k < 3; k++) begin
                    if (dd[8+4*k +: 4] >= 4'd5)
                        dd[8+4*k +: 4] = dd[8+4*k +: 4] + 4'd3;
                end
                dd    = dd << 1;
                bcd_d = dd[19:8];
                sh_d  = dd[7:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7)
                    state_d = COMMIT;
            end
            COMMIT: begin
                hun_d   = bcd_q[11:8];
                ten_d   = bcd_q[7:4];
                one_d   = bcd_q[3:0];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ref_d   = ref_q + DW'(1);
        idx_d   = idx_q;
        if (ref_q == DW'(DIGIT_CYCLES - 1)) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end
        bcnt_d  = bcnt_q + BW'(1);
        blink_d = blink_q;
        if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end
    end

    // Blanked digits still enable their anode; only the segments go dark.
    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = 4'hF;
        unique case (idx_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg7(one_q);
            end
            2'd1: begin
                an_d  = 4'b1101;
                if (hun_q != 4'd0 || ten_q != 4'd0)
                    seg_d = seg7(ten_q);
            end
            2'd2: begin
                an_d  = 4'b1011;
                if (hun_q != 4'd0)
                    seg_d = seg7(hun_q);
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = seg7({1'b0, color});
                dp_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        main_d = 3'b100;
        side_d = 3'b100;
        walk_d = 1'b0;
        case (color)
            3'd0: main_d = 3'b001;
            3'd1: main_d = 3'b010;
            3'd2: side_d = 3'b001;
            3'd3: side_d = 3'b010;
            3'd4: walk_d = 1'b1;
            3'd5: walk_d = blink_q;
            3'd6: begin
                main_d = {blink_q, 2'b00};
                side_d = {blink_q, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            last_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            hun_q   <= '0;
            ten_q   <= '0;
            one_q   <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= 4'hF;
            main_q  <= '0;
            side_q  <= '0;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            hun_q   <= hun_d;
            ten_q   <= ten_d;
            one_q   <= one_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            main_q  <= main_d;
            side_q  <= side_d;
            walk_q  <= walk_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign main_ryg = main_q;
    assign side_ryg = side_q;
    assign ped_walk = walk_q;

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: every cycle compares outputs with a
// timing-level model of conversion latency, digit scan and blink phase.
module tb_countdown_display;

    logic       clk;
    logic       rst;
    logic [7:0] num;
    logic [2:0] color;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [2:0] main_ryg;
    logic [2:0] side_ryg;
    logic       ped_walk;

    int n_cmp;
    int n_bad;
    int cyc;
    int m_busy;
    int m_last;
    int m_disp;
    bit m_valid;

    logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                             7'b0110000, 7'b0011001, 7'b0010010,
                             7'b0000010, 7'b1111000, 7'b0000000,
                             7'b0010000};

    countdown_display #(
        .DIGIT_CYCLES(4),
        .BLINK_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .num(num),
        .color(color),
        .seg(seg),
        .dp(dp),
        .an(an),
        .main_ryg(main_ryg),
        .side_ryg(side_ryg),
        .ped_walk(ped_walk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp,
                   $time);
        end
    endtask

    function automatic logic [6:0] seg_exp(input int pos, input int v,
                                           input int c);
        case (pos)
            0:       seg_exp = SEG[v % 10];
            1:       seg_exp = (v < 10) ? 7'h7F : SEG[(v / 10) % 10];
            2:       seg_exp = (v < 100) ? 7'h7F : SEG[v / 100];
            default: seg_exp = SEG[c];
        endcase
    endfunction

    function automatic logic [6:0] lamp_exp(input int c, input logic p);
        case (c)
            0:       lamp_exp = {3'b001, 3'b100, 1'b0};
            1:       lamp_exp = {3'b010, 3'b100, 1'b0};
            2:       lamp_exp = {3'b100, 3'b001, 1'b0};
            3:       lamp_exp = {3'b100, 3'b010, 1'b0};
            4:       lamp_exp = {3'b100, 3'b100, 1'b1};
            5:       lamp_exp = {3'b100, 3'b100, p};
            6:       lamp_exp = {p, 2'b00, p, 2'b00, 1'b0};
            default: lamp_exp = {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    // One clock: sample inputs seen at the edge, then check outputs
    // against the model state as it stood before that edge.
    task automatic tick();
        logic       r;
        int         n;
        int         c;
        int         pos;
        logic       ph;
        logic [6:0] lx;
        r = rst;
        n = num;
        c = color;
        @(posedge clk);
        #1;
        if (r) begin
            chk("rst_seg", {1'b0, seg}, 8'h7F);
            chk("rst_an", {4'h0, an}, 8'h0F);
            chk("rst_dp", {7'h0, dp}, 8'h01);
            chk("rst_lamps", {1'b0, main_ryg, side_ryg, ped_walk}, 8'h00);
        end else begin
            pos = (cyc / 4) % 4;
            ph  = ((cyc / 8) % 2) == 0;
            lx  = lamp_exp(c, ph);
            chk("an", {4'h0, an}, {4'h0, ~(4'b0001 << pos)});
            chk("seg", {1'b0, seg}, {1'b0, seg_exp(pos, m_disp, c)});
            chk("dp", {7'h0, dp}, {7'h0, pos != 3});
            chk("main", {5'h0, main_ryg}, {5'h0, lx[6:4]});
            chk("side", {5'h0, side_ryg}, {5'h0, lx[3:1]});
            chk("walk", {7'h0, ped_walk}, {7'h0, lx[0]});
            chk("main_1hot", {7'h0, $countones(main_ryg) <= 1}, 8'h01);
        end
        if (r) begin
            cyc     = 0;
            m_busy  = 0;
            m_valid = 1'b0;
            m_disp  = 0;
        end else begin
            cyc++;
            if (m_busy == 0) begin
                if (!m_valid || n != m_last) begin
                    m_last = n;
                    m_busy = 9;
                end
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_disp  = m_last;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int vals [7] = '{0, 9, 10, 99, 100, 255, 240};
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        m_busy  = 0;
        m_last  = 0;
        m_disp  = 0;
        m_valid = 1'b0;
        rst     = 1'b1;
        num     = 8'd0;
        color   = 3'd0;
        repeat (3) tick();

        rst = 1'b0;
        num = 8'd240;
        repeat (24) tick();

        num = 8'd7;
        repeat (24) tick();

        color = 3'd6;
        repeat (40) tick();

        color = 3'd1;
        num   = 8'd30;
        repeat (5) tick();
        num = 8'd29;
        repeat (30) tick();

        num = 8'd123;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (24) tick();

        for (int c = 0; c < 8; c++) begin
            color = 3'(c);
            repeat (3) tick();
        end

        foreach (vals[i]) begin
            num   = 8'(vals[i]);
            color = 3'($urandom_range(0, 7));
            repeat (20) tick();
        end

        for (int i = 0; i < 30; i++) begin
            num   = 8'($urandom_range(0, 255));
            color = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            repeat ($urandom_range(3, 30)) tick();
        end

        repeat (20) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
